jtsdram_bank_fill: RTL and testbench
====================================

// Module: jtsdram_bank_fill
// PURPOSE
//  Write-side companion of the bank read checker: fills one SDRAM bank with a known
//  pattern over the wr/ack/rdy request interface, so the checker can verify it later.
//  Sits between the test sequencer and the SDRAM controller bank port.
//  Writes are issued only while LVBL is high, so accesses stay out of vertical blanking.
//  A watchdog flags a stalled controller.
// PARAMETERS
//  AW       22    address width in 32-bit words; fill covers 0 .. 2^AW-1
//  PATTERN  0     0: din={2{data_ref}}; 1: din={data_ref^addr[15:0], data_ref^addr[15:0]}
//  TOUT     1023  max cycles from wr rising to rdy before err (10-bit watchdog)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-low (rst==0 resets on clk edge)
//  LVBL      in   1   high = active video; requests issue only while high
//  start     in   1   one-cycle pulse: begin/restart fill from address 0
//  data_ref  in   16  reference word, sampled at start, held internally
//  addr      out  AW  word address of current write
//  wr        out  1   write request, held until ack
//  din       out  32  write data for addr
//  ack       in   1   controller accepted request
//  rdy       in   1   controller completed write
//  busy      out  1   fill in progress
//  done      out  1   all 2^AW words written
//  err       out  1   watchdog expired, fill aborted
// BEHAVIOUR
//  Reset: addr=0, wr=0, din=0, busy=0, done=0, err=0, FSM=IDLE, watchdog cleared.
//  FSM: IDLE, REQ, WAIT, HOLD, DONE, FAIL.
//   IDLE : wait for start.
//   start (any state, incl. mid-fill): latch data_ref, addr<=0, done<=0, err<=0, busy<=1.
//     If LVBL=1: wr<=1, go REQ. Else: go HOLD.
//   HOLD : wr=0; when LVBL=1, wr<=1, go REQ.
//   REQ  : wr=1; on ack, wr<=0, go WAIT.
//     If ack and rdy arrive together, treat as completion (as WAIT+rdy) in the same cycle.
//   WAIT : on rdy:
//     addr==all-ones: done<=1, busy<=0, go DONE.
//     Else addr<=addr+1, din recomputed for the new address.
//     If LVBL=1: wr<=1, go REQ; else go HOLD.
//   DONE : done held high until next start.
//   FAIL : err=1, busy=0, wr=0; held until next start.
//  Latency: start at edge N -> wr=1 after edge N+1 (LVBL=1).
//   rdy at edge M -> next wr=1, addr+1 after edge M+1 (no bubble).
//  addr and din are stable from wr rising until rdy; din is a registered function of
//   the latched reference and addr.
//  ack while not in REQ, or rdy in REQ/HOLD without ack: ignored.
//  Watchdog: clears on every wr rising edge and counts in REQ/WAIT; counter saturates,
//   no wrap.
//   Reaching TOUT: wr<=0, go FAIL.
//   Holding LVBL low with no outstanding request (HOLD) does not count.
//  addr increment is AW-bit; terminal test is &addr, so no wrap to 0 during a fill.
//  rst low mid-write: outputs go to reset values at that edge; the controller must
//   tolerate the dropped request.
// STRUCTURE
//  jtsdram_pkg:
//   - FSM state localparams (3-bit)
//   - PATTERN encodings
//   - shared AW default
//  Sub-module jtsdram_wdog: TOUT-parameterized counter
//   - inputs: clk, rst, clr, en
//   - output: expired
//  FSM, address counter and data generator stay in this module.
// TESTING (sim with AW=4, TOUT=15)
//  1 data_ref=16'hA55A, LVBL=1, controller ack+1, rdy+3 -> 16 writes at addr 0..15.
//    Each din=32'hA55AA55A; done=1 after 16th rdy; busy low; wr never set again.
//  2 PATTERN=1, data_ref=16'h00FF -> addr 3 writes din=32'h00FC00FC.
//    addr 15 writes 32'h00F000F0.
//  3 Drop LVBL for 20 cycles after rdy of addr 5 -> wr stays 0, addr=6.
//    wr=1 the cycle after LVBL rises; no err.
//  4 Controller never returns rdy for addr 2 -> err=1 15 cycles after wr rose.
//    wr=0, busy=0, done=0; next start clears err and restarts at addr 0.
//  5 ack and rdy same cycle every write -> one write per 2 cycles; done after 32 cycles.
//  6 start pulse at addr 9 -> addr=0 next cycle, new data_ref latched.
//    rst=0 mid-write -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank test blocks.
//  - fill_state_t : bank fill FSM states (3-bit encoding)
//  - PAT_*        : write-data pattern selectors
//  - JTS_AW_DEF   : default bank address width in 32-bit words
//  - fill_word()  : write data for a given pattern, reference word and address
package jtsdram_pkg;

    localparam int JTS_AW_DEF = 22;

    localparam int PAT_DUP = 0;   // din = {ref, ref}
    localparam int PAT_XOR = 1;   // din = {ref^addr, ref^addr}

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4,
        ST_FAIL = 3'd5
    } fill_state_t;

    // The read checker recomputes the same word, so both sides must agree on
    // this function for a given pattern.
    function automatic logic [31:0] fill_word(input int          pattern,
                                              input logic [15:0] ref_w,
                                              input logic [15:0] a);
        logic [15:0] w;
        w = (pattern == PAT_XOR) ? (ref_w ^ a) : ref_w;
        return {w, w};
    endfunction

endpackage

// File: rtl/jtsdram_wdog.sv
// Request watchdog for the bank fill.
//  clk     : system clock
//  rst     : synchronous reset, active-low
//  clr     : restart the count (a new request is being issued)
//  en      : a request is outstanding, count this cycle
//  expired : TOUT cycles have elapsed since the last clr, counting this one
module jtsdram_wdog #(
    parameter int TOUT = 1023
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CW   = $clog2(TOUT + 1);
    localparam logic [CW-1:0]   TOP  = CW'(TOUT);
    localparam logic [CW-1:0]   LAST = CW'(TOUT - 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of counted cycles already elapsed, so the cycle in
    // which cnt==TOUT-1 is the TOUT-th one. Saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != TOP)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/jtsdram_bank_fill.sv
// Fills one SDRAM bank (addresses 0 .. 2^AW-1) with a known pattern through
// the wr/ack/rdy bank port, so the read checker can verify it afterwards.
// New requests are only issued while LVBL is high.
//  clk, rst  : clock, synchronous active-low reset
//  LVBL      : high during active video; gates issuing of new requests
//  start     : one-cycle pulse, (re)start the fill at address 0
//  data_ref  : reference word, captured on start
//  addr, din : address and data of the current write (stable until rdy)
//  wr        : write request, held until ack
//  ack, rdy  : controller accepted / completed the request
//  busy      : fill in progress
//  done      : whole bank written
//  err       : watchdog expired, fill aborted
module jtsdram_bank_fill
    import jtsdram_pkg::*;
#(
    parameter int AW      = JTS_AW_DEF,
    parameter int PATTERN = PAT_DUP,
    parameter int TOUT    = 1023
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          start,
    input  logic [15:0]   data_ref,
    output logic [AW-1:0] addr,
    output logic          wr,
    output logic [31:0]   din,
    input  logic          ack,
    input  logic          rdy,
    output logic          busy,
    output logic          done,
    output logic          err
);

    fill_state_t   st, st_nxt;
    logic [15:0]   ref_q, ref_nxt;
    logic [AW-1:0] addr_nxt;
    logic          wr_nxt, busy_nxt, done_nxt, err_nxt;
    logic          issue, complete, abort;
    logic          expired;

    jtsdram_wdog #(.TOUT(TOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (issue),
        .en      (st == ST_REQ || st == ST_WAIT),
        .expired (expired)
    );

    always_comb begin
        st_nxt   = st;
        ref_nxt  = ref_q;
        addr_nxt = addr;
        wr_nxt   = wr;
        busy_nxt = busy;
        done_nxt = done;
        err_nxt  = err;
        issue    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;

        if (start) begin
            ref_nxt  = data_ref;
            addr_nxt = '0;
            done_nxt = 1'b0;
            err_nxt  = 1'b0;
            busy_nxt = 1'b1;
            if (LVBL) begin
                wr_nxt = 1'b1;
                issue  = 1'b1;
                st_nxt = ST_REQ;
            end else begin
                wr_nxt = 1'b0;
                st_nxt = ST_HOLD;
            end
        end else begin
            case (st)
                ST_HOLD: if (LVBL) begin
                    wr_nxt = 1'b1;
                    issue  = 1'b1;
                    st_nxt = ST_REQ;
                end
                // ack+rdy together is a finished write; a real completion
                // takes precedence over a watchdog expiring in the same cycle.
                ST_REQ: begin
                    if (ack) begin
                        wr_nxt   = 1'b0;
                        st_nxt   = ST_WAIT;
                        complete = rdy;
                    end else if (expired) begin
                        abort = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (rdy)
                        complete = 1'b1;
                    else if (expired)
                        abort = 1'b1;
                end
                default: ;
            endcase

            if (complete) begin
                if (&addr) begin
                    wr_nxt   = 1'b0;
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                    st_nxt   = ST_DONE;
                end else begin
                    addr_nxt = addr + 1'b1;
                    if (LVBL) begin
                        wr_nxt = 1'b1;
                        issue  = 1'b1;
                        st_nxt = ST_REQ;
                    end else begin
                        wr_nxt = 1'b0;
                        st_nxt = ST_HOLD;
                    end
                end
            end

            if (abort) begin
                wr_nxt   = 1'b0;
                err_nxt  = 1'b1;
                busy_nxt = 1'b0;
                st_nxt   = ST_FAIL;
            end
        end
    end

    // din follows the next address/reference so it is valid in the same cycle
    // wr rises and stays put until the write completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st    <= ST_IDLE;
            ref_q <= '0;
            addr  <= '0;
            wr    <= 1'b0;
            din   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            st    <= st_nxt;
            ref_q <= ref_nxt;
            addr  <= addr_nxt;
            wr    <= wr_nxt;
            din   <= fill_word(PATTERN, ref_nxt, 16'(addr_nxt));
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_jtsdram_bank_fill.sv
module tb_jtsdram_bank_fill;

    localparam int AW   = 4;
    localparam int TOUT = 15;
    localparam int N    = 1 << AW;

    logic          clk, rst, LVBL, start, ack, rdy;
    logic [15:0]   data_ref;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   din0, din1;
    logic          wr0, wr1, busy0, busy1, done0, done1, err0, err1;

    // Same stimulus into both pattern variants; only din differs between them.
    jtsdram_bank_fill #(.AW(AW), .PATTERN(0), .TOUT(TOUT)) dut0 (
        .clk(clk), .rst(rst), .LVBL(LVBL), .start(start), .data_ref(data_ref),
        .addr(addr0), .wr(wr0), .din(din0), .ack(ack), .rdy(rdy),
        .busy(busy0), .done(done0), .err(err0));

    jtsdram_bank_fill #(.AW(AW), .PATTERN(1), .TOUT(TOUT)) dut1 (
        .clk(clk), .rst(rst), .LVBL(LVBL), .start(start), .data_ref(data_ref),
        .addr(addr1), .wr(wr1), .din(din1), .ack(ack), .rdy(rdy),
        .busy(busy1), .done(done1), .err(err1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0;

    // Controller model state
    bit          c_act, cap_now, rand_lat, lvbl_rand;
    int          c_k, c_ack, c_rdy, cap_addr, hang_addr;
    logic [31:0] cap_din;
    int          lvbl_viol, stab_viol;
    int          q_addr[$];
    logic [31:0] q_din0[$], q_din1[$];

    function automatic logic [31:0] model_din(input int pat, input logic [15:0] r, input int a);
        logic [15:0] w;
        w = (pat == 1) ? (r ^ 16'(a)) : r;
        return {w, w};
    endfunction

    // -1: the captured writes are exactly 0..N-1 with the model data; -2: wrong count
    function automatic int seq_bad(input logic [15:0] r);
        if (q_addr.size() != N) return -2;
        for (int i = 0; i < N; i++)
            if (q_addr[i] != i || q_din0[i] !== model_din(0, r, i) || q_din1[i] !== model_din(1, r, i))
                return i;
        return -1;
    endfunction

    // One clock: sample at negedge, then drive the controller response for the next edge.
    task automatic tick();
        logic lv;
        lv = LVBL;
        @(negedge clk);
        cap_now = 1'b0;
        ack = 1'b0;
        rdy = 1'b0;
        if (c_act && (int'(addr0) != cap_addr || din0 !== cap_din)) stab_viol++;
        if (rst && !c_act && wr0 === 1'b1) begin
            c_act = 1'b1; c_k = 0; cap_now = 1'b1;
            cap_addr = int'(addr0); cap_din = din0;
            q_addr.push_back(cap_addr); q_din0.push_back(din0); q_din1.push_back(din1);
            if (!lv) lvbl_viol++;
            if (rand_lat) begin
                c_ack = $urandom_range(1, 3);
                c_rdy = c_ack + $urandom_range(0, 4);
            end
        end
        if (c_act) begin
            c_k++;
            if (c_k == c_ack) ack = 1'b1;
            if (c_k == c_rdy && cap_addr != hang_addr) begin
                rdy = 1'b1;
                c_act = 1'b0;
            end
        end
        if (lvbl_rand) LVBL = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_start(input logic [15:0] r);
        data_ref = r; start = 1'b1;
        c_act = 1'b0; ack = 1'b0; rdy = 1'b0;
        q_addr.delete(); q_din0.delete(); q_din1.delete();
        lvbl_viol = 0; stab_viol = 0;
        tick();
        start = 1'b0;
        data_ref = 16'($urandom);
    endtask

    task automatic run_to_end(input int budget);
        for (int i = 0; i < budget && !done0 && !err0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; LVBL = 1'b1; start = 1'b0; ack = 1'b0; rdy = 1'b0; data_ref = '0;
        c_act = 1'b0; hang_addr = -1; rand_lat = 1'b0; lvbl_rand = 1'b0;
        tick(); tick();
        n_chk++; if (addr0 !== '0)  $display("FAIL reset_addr: got %0h want 0", addr0); else n_pass++;
        n_chk++; if (wr0 !== 1'b0)  $display("FAIL reset_wr: got %b want 0", wr0); else n_pass++;
        n_chk++; if (din0 !== '0)   $display("FAIL reset_din0: got %h want 0", din0); else n_pass++;
        n_chk++; if (din1 !== '0)   $display("FAIL reset_din1: got %h want 0", din1); else n_pass++;
        n_chk++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
        n_chk++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else n_pass++;
        n_chk++; if (err0 !== 1'b0)  $display("FAIL reset_err: got %b want 0", err0); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int bad;
        rand_lat = 1'b0; c_ack = 1; c_rdy = 3; LVBL = 1'b1;
        pulse_start(16'hA55A);
        n_chk++; if (wr0 !== 1'b1 || addr0 !== '0) $display("FAIL basic_start_lat: got wr=%b addr=%0d want wr=1 addr=0", wr0, addr0); else n_pass++;
        n_chk++; if (busy0 !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy0); else n_pass++;
        run_to_end(500);
        bad = seq_bad(16'hA55A);
        n_chk++; if (bad != -1) $display("FAIL basic_seq: got %0d writes, bad idx %0d want %0d writes, idx -1", q_addr.size(), bad, N); else n_pass++;
        n_chk++; if (done0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 1'b0)
            $display("FAIL basic_end: got done=%b busy=%b err=%b want 1 0 0", done0, busy0, err0); else n_pass++;
        for (int i = 0; i < 10; i++) tick();
        n_chk++; if (q_addr.size() != N || wr0 !== 1'b0 || done0 !== 1'b1)
            $display("FAIL basic_quiet: got writes=%0d wr=%b done=%b want %0d 0 1", q_addr.size(), wr0, done0, N); else n_pass++;
    endtask

    task automatic test_pattern();
        int bad;
        logic [31:0] d3, d15;
        rand_lat = 1'b1; LVBL = 1'b1;
        pulse_start(16'h00FF);
        run_to_end(800);
        bad = seq_bad(16'h00FF);
        n_chk++; if (bad != -1) $display("FAIL pattern_seq: got %0d writes, bad idx %0d want %0d, -1", q_addr.size(), bad, N); else n_pass++;
        d3  = (q_din1.size() > 3)  ? q_din1[3]  : 32'hxxxxxxxx;
        d15 = (q_din1.size() > 15) ? q_din1[15] : 32'hxxxxxxxx;
        n_chk++; if (d3 !== 32'h00FC00FC)  $display("FAIL pattern_addr3: got %h want 00fc00fc", d3); else n_pass++;
        n_chk++; if (d15 !== 32'h00F000F0) $display("FAIL pattern_addr15: got %h want 00f000f0", d15); else n_pass++;
    endtask

    task automatic test_lvbl();
        logic [15:0] r;
        int bad, wrhi, i;
        r = 16'($urandom);
        rand_lat = 1'b0; c_ack = 1; c_rdy = 2; LVBL = 1'b1;
        pulse_start(r);
        for (i = 0; i < 300; i++) begin
            tick();
            if (rdy && cap_addr == 5) break;
        end
        LVBL = 1'b0;
        wrhi = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wr0 !== 1'b0) wrhi++;
        end
        n_chk++; if (wrhi != 0) $display("FAIL lvbl_wr_low: got %0d cycles with wr high want 0", wrhi); else n_pass++;
        n_chk++; if (addr0 !== 4'd6 || busy0 !== 1'b1) $display("FAIL lvbl_hold: got addr=%0d busy=%b want 6 1", addr0, busy0); else n_pass++;
        LVBL = 1'b1;
        tick();
        n_chk++; if (wr0 !== 1'b1 || addr0 !== 4'd6) $display("FAIL lvbl_resume: got wr=%b addr=%0d want 1 6", wr0, addr0); else n_pass++;
        run_to_end(500);
        bad = seq_bad(r);
        n_chk++; if (bad != -1) $display("FAIL lvbl_seq: got %0d writes, bad idx %0d want %0d, -1", q_addr.size(), bad, N); else n_pass++;
        n_chk++; if (err0 !== 1'b0 || done0 !== 1'b1) $display("FAIL lvbl_end: got err=%b done=%b want 0 1", err0, done0); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [15:0] r;
        int n, bad;
        rand_lat = 1'b0; c_ack = 1; c_rdy = 2; LVBL = 1'b1; hang_addr = 2;
        pulse_start(16'h1234);
        for (int i = 0; i < 200 && !(cap_now && cap_addr == 2); i++) tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (err0 === 1'b1) break;
        end
        n_chk++; if (n != TOUT) $display("FAIL tout_latency: got err after %0d cycles want %0d", n, TOUT); else n_pass++;
        n_chk++; if (err0 !== 1'b1 || wr0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0)
            $display("FAIL tout_state: got err=%b wr=%b busy=%b done=%b want 1 0 0 0", err0, wr0, busy0, done0); else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        n_chk++; if (err0 !== 1'b1 || wr0 !== 1'b0) $display("FAIL tout_hold: got err=%b wr=%b want 1 0", err0, wr0); else n_pass++;
        hang_addr = -1;
        r = 16'($urandom);
        pulse_start(r);
        n_chk++; if (err0 !== 1'b0 || addr0 !== '0 || wr0 !== 1'b1)
            $display("FAIL tout_restart: got err=%b addr=%0d wr=%b want 0 0 1", err0, addr0, wr0); else n_pass++;
        run_to_end(500);
        bad = seq_bad(r);
        n_chk++; if (bad != -1 || done0 !== 1'b1) $display("FAIL tout_refill: got bad idx %0d done=%b want -1 1", bad, done0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n, wrlo, bad;
        logic [15:0] r;
        r = 16'($urandom);
        rand_lat = 1'b0; c_ack = 2; c_rdy = 2; LVBL = 1'b1;
        pulse_start(r);
        n = 0; wrlo = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (done0 === 1'b1) break;
            if (wr0 !== 1'b1) wrlo++;
        end
        n_chk++; if (n != 2 * N) $display("FAIL b2b_cycles: got done after %0d cycles want %0d", n, 2 * N); else n_pass++;
        n_chk++; if (wrlo != 0) $display("FAIL b2b_bubble: got %0d cycles with wr low want 0", wrlo); else n_pass++;
        bad = seq_bad(r);
        n_chk++; if (bad != -1) $display("FAIL b2b_seq: got %0d writes, bad idx %0d want %0d, -1", q_addr.size(), bad, N); else n_pass++;
    endtask

    task automatic test_restart();
        logic [15:0] r1, r2;
        int bad;
        r1 = 16'($urandom); r2 = ~r1;
        rand_lat = 1'b1; LVBL = 1'b1;
        pulse_start(r1);
        for (int i = 0; i < 300 && !(cap_now && cap_addr == 9); i++) tick();
        n_chk++; if (addr0 !== 4'd9) $display("FAIL restart_reach9: got addr=%0d want 9", addr0); else n_pass++;
        pulse_start(r2);
        n_chk++; if (addr0 !== '0 || wr0 !== 1'b1) $display("FAIL restart_addr: got addr=%0d wr=%b want 0 1", addr0, wr0); else n_pass++;
        n_chk++; if (din0 !== model_din(0, r2, 0) || din1 !== model_din(1, r2, 0))
            $display("FAIL restart_ref: got %h %h want %h %h", din0, din1, model_din(0, r2, 0), model_din(1, r2, 0)); else n_pass++;
        run_to_end(800);
        bad = seq_bad(r2);
        n_chk++; if (bad != -1) $display("FAIL restart_seq: got %0d writes, bad idx %0d want %0d, -1", q_addr.size(), bad, N); else n_pass++;

        pulse_start(16'($urandom));
        for (int i = 0; i < 300 && !(cap_now && cap_addr == 4); i++) tick();
        rst = 1'b0;
        tick();
        c_act = 1'b0;
        n_chk++; if (addr0 !== '0 || wr0 !== 1'b0 || din0 !== '0 || din1 !== '0)
            $display("FAIL rst_mid_data: got addr=%0d wr=%b din0=%h din1=%h want 0 0 0 0", addr0, wr0, din0, din1); else n_pass++;
        n_chk++; if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0)
            $display("FAIL rst_mid_flags: got busy=%b done=%b err=%b want 0 0 0", busy0, done0, err0); else n_pass++;
        rst = 1'b1; LVBL = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_chk++; if (wr0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL rst_idle: got wr=%b busy=%b want 0 0", wr0, busy0); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] r;
        int bad;
        for (int it = 0; it < 4; it++) begin
            r = 16'($urandom);
            rand_lat = 1'b1; lvbl_rand = 1'b1;
            pulse_start(r);
            run_to_end(3000);
            lvbl_rand = 1'b0; LVBL = 1'b1;
            bad = seq_bad(r);
            n_chk++; if (bad != -1) $display("FAIL rand_seq[%0d]: got %0d writes, bad idx %0d want %0d, -1", it, q_addr.size(), bad, N); else n_pass++;
            n_chk++; if (done0 !== 1'b1 || err0 !== 1'b0) $display("FAIL rand_end[%0d]: got done=%b err=%b want 1 0", it, done0, err0); else n_pass++;
            n_chk++; if (lvbl_viol != 0) $display("FAIL rand_lvbl[%0d]: got %0d requests issued in blanking want 0", it, lvbl_viol); else n_pass++;
            n_chk++; if (stab_viol != 0) $display("FAIL rand_stable[%0d]: got %0d addr/din changes mid-write want 0", it, stab_viol); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pattern();
        test_lvbl();
        test_timeout();
        test_back_to_back();
        test_restart();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
